// File: rtl/conv_window_gen.sv
// Streaming KxK sliding-window generator for the convolution MAC.
// Line buffers plus a KxK shift array; one registered output stage.
module conv_window_gen #(
    parameter int KERNEL_SIZE = 3,
    parameter int INT_WIDTH   = 12,
    parameter int FRAC_WIDTH  = 20,
    parameter int IMG_WIDTH   = 8,
    parameter int IMG_HEIGHT  = 8
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic signed [INT_WIDTH+FRAC_WIDTH-1:0] pix_in,
    input  logic                                  pix_valid,
    output logic                                  pix_ready,
    output logic signed [INT_WIDTH+FRAC_WIDTH-1:0] win_out [0:KERNEL_SIZE*KERNEL_SIZE-1],
    output logic                                  win_valid,
    input  logic                                  win_ready,
    output logic                                  win_last
);

    localparam int PW = INT_WIDTH + FRAC_WIDTH;
    localparam int K  = KERNEL_SIZE;
    localparam int KK = KERNEL_SIZE * KERNEL_SIZE;
    localparam int CW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

    logic [CW-1:0] col;
    logic [RW-1:0] row;

    // Line buffers are not reset: each slot is rewritten before a window uses it.
    logic signed [PW-1:0] lbuf [0:K-2][0:IMG_WIDTH-1];
    logic signed [PW-1:0] sreg [0:K-1][0:K-1];
    logic signed [PW-1:0] vcol [0:K-1];
    logic signed [PW-1:0] nwin [0:KK-1];

    logic accept;
    logic emit;
    logic col_end;
    logic row_end;

    assign pix_ready = !win_valid || win_ready;
    assign accept    = pix_valid && pix_ready;
    assign col_end   = (col == CW'(IMG_WIDTH - 1));
    assign row_end   = (row == RW'(IMG_HEIGHT - 1));
    assign emit      = accept
                       && (row >= RW'(K - 1))
                       && (col >= CW'(K - 1));

    // Vertical column (oldest line on top) and the window after the next shift.
    always_comb begin
        for (int r = 0; r < K - 1; r++) begin
            vcol[r] = lbuf[r][col];
        end
        vcol[K-1] = pix_in;
        for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K - 1; c++) begin
                nwin[r*K+c] = sreg[r][c+1];
            end
            nwin[r*K+K-1] = vcol[r];
        end
    end

    // Raster position of the next pixel; wraps at frame end for gapless frames.
    always_ff @(posedge clk) begin
        if (rst) begin
            col <= '0;
            row <= '0;
        end else if (accept) begin
            if (col_end) begin
                col <= '0;
                row <= row_end ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    // Each line buffer slot moves up one line; the new pixel enters at the bottom.
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int i = 0; i < K - 2; i++) begin
                lbuf[i][col] <= lbuf[i+1][col];
            end
            lbuf[K-2][col] <= pix_in;
        end
    end

    // Window shift array: columns move left, the new vertical column enters right.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < K; r++) begin
                for (int c = 0; c < K; c++) begin
                    sreg[r][c] <= '0;
                end
            end
        end else if (accept) begin
            for (int r = 0; r < K; r++) begin
                for (int c = 0; c < K; c++) begin
                    sreg[r][c] <= nwin[r*K+c];
                end
            end
        end
    end

    // Output register: load on an emitting accept, clear valid once consumed.
    always_ff @(posedge clk) begin
        if (rst) begin
            win_valid <= 1'b0;
            win_last  <= 1'b0;
            for (int i = 0; i < KK; i++) begin
                win_out[i] <= '0;
            end
        end else if (emit) begin
            win_valid <= 1'b1;
            win_last  <= col_end && row_end;
            win_out   <= nwin;
        end else if (win_ready) begin
            win_valid <= 1'b0;
            win_last  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_conv_window_gen.sv
// Self-checking bench for conv_window_gen (K=3, 4x4 frames).
// Reference model rebuilds each frame in an array and cuts windows from it.
module tb_conv_window_gen;

    localparam int K  = 3;
    localparam int W  = 4;
    localparam int H  = 4;
    localparam int PW = 32;
    localparam int KK = K * K;

    typedef logic [KK-1:0][PW-1:0] wvec_t;
    typedef struct packed {
        logic  last;
        wvec_t w;
    } win_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic signed [PW-1:0] pix_in = '0;
    logic pix_valid = 1'b0;
    logic pix_ready;
    logic signed [PW-1:0] dut_win [0:KK-1];
    logic win_valid;
    logic win_ready = 1'b1;
    logic win_last;

    conv_window_gen #(
        .KERNEL_SIZE(K),
        .INT_WIDTH(12),
        .FRAC_WIDTH(20),
        .IMG_WIDTH(W),
        .IMG_HEIGHT(H)
    ) dut (
        .clk(clk),
        .rst(rst),
        .pix_in(pix_in),
        .pix_valid(pix_valid),
        .pix_ready(pix_ready),
        .win_out(dut_win),
        .win_valid(win_valid),
        .win_ready(win_ready),
        .win_last(win_last)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    bit chk_en = 0;
    bit rnd_valid = 0;
    bit rnd_ready = 0;
    bit stall_req = 0;

    win_t q[$];
    win_t seen[$];
    win_t ref1[$];

    logic [PW-1:0] img [0:H-1][0:W-1];
    int mr = 0;
    int mc = 0;

    int first_idx[KK] = '{0, 1, 2, 4, 5, 6, 8, 9, 10};
    int last_idx[KK]  = '{5, 6, 7, 9, 10, 11, 13, 14, 15};

    function automatic wvec_t dut_vec();
        wvec_t v;
        for (int i = 0; i < KK; i++) v[i] = dut_win[i];
        return v;
    endfunction

    function automatic wvec_t lit(input int v[KK], input int off);
        wvec_t w;
        for (int i = 0; i < KK; i++) w[i] = 32'(v[i] + off) << 20;
        return w;
    endfunction

    function automatic string w2s(input wvec_t w);
        string s = "";
        for (int i = 0; i < KK; i++) s = {s, $sformatf("%h ", w[i])};
        return s;
    endfunction

    task automatic check(input string nm, input bit ok,
                         input string act, input string exp);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL %s: got %s expected %s", nm, act, exp);
        end
    endtask

    task automatic model_accept(input logic [PW-1:0] v);
        win_t e;
        img[mr][mc] = v;
        if (mr >= K - 1 && mc >= K - 1) begin
            for (int i = 0; i < K; i++)
                for (int j = 0; j < K; j++)
                    e.w[i*K+j] = img[mr-K+1+i][mc-K+1+j];
            e.last = (mr == H - 1) && (mc == W - 1);
            q.push_back(e);
        end
        if (mc == W - 1) begin
            mc = 0;
            mr = (mr == H - 1) ? 0 : mr + 1;
        end else begin
            mc++;
        end
    endtask

    win_t act;
    bit   exp_v;

    // Per-cycle comparison of the DUT against the model's pending window.
    always @(negedge clk) begin
        if (chk_en) begin
            exp_v = (q.size() != 0);
            act.w = dut_vec();
            act.last = win_last;
            check("win_valid", win_valid === exp_v,
                  $sformatf("%b", win_valid), $sformatf("%b", exp_v));
            if (exp_v && win_valid === 1'b1) begin
                check("win_out", act.w === q[0].w, w2s(act.w), w2s(q[0].w));
                check("win_last", win_last === q[0].last,
                      $sformatf("%b", win_last), $sformatf("%b", q[0].last));
            end
            check("pix_ready", pix_ready === (!win_valid || win_ready),
                  $sformatf("%b", pix_ready),
                  $sformatf("%b", !win_valid || win_ready));
            if (win_valid && win_ready && q.size() != 0) begin
                seen.push_back(act);
                void'(q.pop_front());
            end
            if (rst) begin
                q.delete();
                mr = 0;
                mc = 0;
            end else if (pix_valid && pix_ready) begin
                model_accept(pix_in);
            end
        end
    end

    wvec_t snap;

    // Downstream ready: always-on, random, or a one-shot 5-cycle stall.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (stall_req && win_valid) begin
                stall_req = 0;
                win_ready = 1'b0;
                snap = dut_vec();
                repeat (5) begin
                    #2;
                    check("stall_pix_ready", pix_ready === 1'b0,
                          $sformatf("%b", pix_ready), "0");
                    check("stall_hold", dut_vec() === snap && win_valid === 1'b1,
                          w2s(dut_vec()), w2s(snap));
                    @(posedge clk);
                    #1;
                end
                win_ready = 1'b1;
            end else if (rnd_ready) begin
                win_ready = 1'($urandom_range(0, 1));
            end else begin
                win_ready = 1'b1;
            end
        end
    end

    task automatic send_px(input logic [PW-1:0] v);
        bit acc = 0;
        int tries = 0;
        pix_in = v;
        while (!acc) begin
            pix_valid = (rnd_valid && $urandom_range(0, 1) == 0) ? 1'b0 : 1'b1;
            @(negedge clk);
            acc = pix_valid && pix_ready;
            @(posedge clk);
            #1;
            tries++;
            if (!acc && tries > 200) begin
                check("accept_timeout", 1'b0, "no accept", "accept");
                acc = 1;
            end
        end
        pix_valid = 1'b0;
    endtask

    task automatic send_pixels(input int base, input bit neg, input int n);
        for (int p = 0; p < n; p++) begin
            if (neg) send_px(32'hFFF00000);
            else send_px(32'(p << 20) + 32'(base));
        end
    endtask

    task automatic drain();
        repeat (6) @(posedge clk);
        #1;
    endtask

    function automatic bit seq_eq(input win_t a[$], input win_t b[$]);
        if (a.size() != b.size()) return 0;
        foreach (a[i]) if (a[i] !== b[i]) return 0;
        return 1;
    endfunction

    initial begin
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk_en = 1;
        check("rst_valid", win_valid === 1'b0, $sformatf("%b", win_valid), "0");
        check("rst_last", win_last === 1'b0, $sformatf("%b", win_last), "0");
        check("rst_win", dut_vec() === '0, w2s(dut_vec()), "all zero");
        check("rst_ready", pix_ready === 1'b1, $sformatf("%b", pix_ready), "1");

        // Scenario 1: plain ramp frame
        seen.delete();
        send_pixels(0, 0, W * H);
        drain();
        check("s1_count", seen.size() == 4, $sformatf("%0d", seen.size()), "4");
        if (seen.size() == 4) begin
            check("s1_first", seen[0].w === lit(first_idx, 0),
                  w2s(seen[0].w), w2s(lit(first_idx, 0)));
            check("s1_lastwin", seen[3].w === lit(last_idx, 0),
                  w2s(seen[3].w), w2s(lit(last_idx, 0)));
            for (int i = 0; i < 4; i++)
                check("s1_lastflag", seen[i].last === (i == 3),
                      $sformatf("%b", seen[i].last), $sformatf("%b", i == 3));
        end
        ref1 = seen;

        // Scenario 2: downstream stall after the first window
        seen.delete();
        stall_req = 1;
        send_pixels(0, 0, W * H);
        drain();
        check("s2_seq", seq_eq(seen, ref1),
              $sformatf("%0d windows", seen.size()), "scenario 1 sequence");

        // Scenario 3: two frames back-to-back
        seen.delete();
        send_pixels(0, 0, W * H);
        send_pixels(100 << 20, 0, W * H);
        drain();
        check("s3_count", seen.size() == 8, $sformatf("%0d", seen.size()), "8");
        if (seen.size() == 8)
            check("s3_f2first", seen[4].w === lit(first_idx, 100),
                  w2s(seen[4].w), w2s(lit(first_idx, 100)));

        // Scenario 4: negative constant data
        seen.delete();
        send_pixels(0, 1, W * H);
        drain();
        check("s4_count", seen.size() == 4, $sformatf("%0d", seen.size()), "4");
        foreach (seen[i])
            check("s4_neg", seen[i].w === {KK{32'hFFF00000}},
                  w2s(seen[i].w), "all fff00000");

        // Scenario 5: reset mid-frame then a fresh frame
        send_pixels(0, 0, 7);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("s5_valid", win_valid === 1'b0, $sformatf("%b", win_valid), "0");
        check("s5_win", dut_vec() === '0, w2s(dut_vec()), "all zero");
        seen.delete();
        send_pixels(0, 0, W * H);
        drain();
        check("s5_seq", seq_eq(seen, ref1),
              $sformatf("%0d windows", seen.size()), "scenario 1 sequence");

        // Scenario 6: random pix_valid
        seen.delete();
        rnd_valid = 1;
        send_pixels(0, 0, W * H);
        drain();
        check("s6_seq", seq_eq(seen, ref1),
              $sformatf("%0d windows", seen.size()), "scenario 1 sequence");

        // Scenario 7: random data, random valid and ready
        seen.delete();
        rnd_ready = 1;
        for (int f = 0; f < 4; f++)
            for (int p = 0; p < W * H; p++) send_px($urandom);
        rnd_ready = 0;
        rnd_valid = 0;
        drain();
        check("s7_count", seen.size() == 16, $sformatf("%0d", seen.size()), "16");
        check("drain_empty", q.size() == 0, $sformatf("%0d", q.size()), "0");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/conv_window_gen.md
Name: conv_window_gen

Overview:
- Streaming 2-D sliding-window generator that sits directly upstream of the convolution MAC.
- Accepts one signed Q12.20 pixel per handshake, in raster order.
- Buffers KERNEL_SIZE-1 image lines and emits, per valid output position, a KERNEL_SIZE x KERNEL_SIZE window in the flat layout the MAC's din array expects.
- "Valid" padding only: no border padding; window count per frame is (IMG_WIDTH-KERNEL_SIZE+1)*(IMG_HEIGHT-KERNEL_SIZE+1).

Parameters:
- KERNEL_SIZE, 3, window edge length (>=2).
- INT_WIDTH, 12, integer bits of the Q-format pixel.
- FRAC_WIDTH, 20, fractional bits of the Q-format pixel.
- IMG_WIDTH, 8, pixels per line (>=KERNEL_SIZE).
- IMG_HEIGHT, 8, lines per frame (>=KERNEL_SIZE).

Ports:
- clk  input  1  single clock; all state on rising edge.
- rst  input  1  synchronous, active-high reset.
- pix_in  input  signed INT_WIDTH+FRAC_WIDTH  Q12.20 input pixel.
- pix_valid  input  1  pix_in is valid.
- pix_ready  output  1  block can accept a pixel this cycle.
- win_out  output  signed INT_WIDTH+FRAC_WIDTH, array [0:KERNEL_SIZE*KERNEL_SIZE-1]  window; feeds the MAC din.
- win_valid  output  1  win_out holds a valid window.
- win_ready  input  1  downstream consumes the window.
- win_last  output  1  qualifies win_valid; marks the final window of a frame.

Behaviour:
- Reset:
  - win_valid=0, win_last=0, all win_out elements=0.
  - Column/row counters=0; window shift registers=0.
  - Line-buffer RAM contents are not reset. They are never exposed before being overwritten.
- Handshakes:
  - Input accept = pix_valid & pix_ready.
  - Output transfer = win_valid & win_ready.
  - pix_ready = !win_valid | win_ready (combinational; single output register stage). pix_ready=1 out of reset.
- Counters:
  - col counts 0..IMG_WIDTH-1 and row counts 0..IMG_HEIGHT-1, advancing only on accept.
  - col wraps to 0 and increments row.
  - At (IMG_HEIGHT-1, IMG_WIDTH-1), both wrap to 0, so back-to-back frames need no gap.
- Storage:
  - KERNEL_SIZE-1 line buffers, each IMG_WIDTH deep, indexed by col. They form a vertical column of KERNEL_SIZE pixels per accept.
  - That column shifts into a KERNEL_SIZE x KERNEL_SIZE register array.
- Window layout:
  - win_out[r*KERNEL_SIZE+c] = pixel(row-KERNEL_SIZE+1+r, col-KERNEL_SIZE+1+c), where (row, col) is the accepted pixel.
  - r=0 is the top row; c=0 is the left column.
- Emission:
  - An accept at row>=KERNEL_SIZE-1 and col>=KERNEL_SIZE-1 loads win_out and sets win_valid on the next edge (latency 1 cycle after accept).
  - Accepts at col<KERNEL_SIZE-1 only shift. The window then holds the previous line's tail, so no window is emitted.
  - Accepts at row<KERNEL_SIZE-1 also only fill buffers; no window is emitted.
- win_last = 1 with the window produced by pixel (IMG_HEIGHT-1, IMG_WIDTH-1); 0 otherwise.
- Hold rule: while win_valid & !win_ready, win_out, win_valid and win_last hold stable, and pix_ready=0.
- Simultaneous transfer and new window (win_ready=1 and an emitting accept in the same cycle): win_valid stays 1 and win_out updates to the new window. No bubble and no loss.
- Transfer with a non-emitting accept: win_valid drops to 0.
- Arithmetic: none. Pixels pass bit-exact, sign preserved, no truncation or rounding.
- Reset mid-frame: discards the partial frame and any pending window. The next accepted pixel is treated as (0,0).

Test Plan:
- W=H=4, K=3, pix_in=(r*4+c)<<20, pix_valid=1, win_ready=1:
  - First win_valid 1 cycle after pixel 10 is accepted, with win_out = {0,1,2,4,5,6,8,9,10}<<20.
  - Exactly 4 windows total.
  - Last window {5,6,7,9,10,11,13,14,15}<<20 with win_last=1, asserted only on that window.
- Same stimulus, win_ready=0 for 5 cycles after the first window:
  - pix_ready=0 and win_out unchanged throughout.
  - After release, the remaining 3 windows arrive in order with no duplicates or drops.
- Two frames back-to-back, second frame pixel = first + (100<<20):
  - Second frame's first window = {100,101,102,104,105,106,108,109,110}<<20.
  - No window is emitted from cross-frame data.
- Negative data, all pixels 32'hFFF00000 (-1.0): every window element is 32'hFFF00000.
- rst pulsed after 7 pixels accepted, then a fresh 16-pixel frame:
  - win_valid=0 and win_out all zero after reset.
  - The subsequent output matches scenario 1 exactly.
- pix_valid toggled randomly (50%) with win_ready=1: window sequence identical to scenario 1.
